// File: rtl/mips_cpu_lsu_if.sv
// Core-side request/response handshake plus Avalon-MM master signals of the
// MIPS load/store unit. The master modport is the LSU's view of the bundle;
// the slave modport is the environment's view (the core and the memory).
interface mips_cpu_lsu_if;
  // core request / response
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  // Avalon-MM master
  logic [31:0] address;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  modport master (
    input  req_valid, req_op, req_addr, req_wdata, waitrequest, readdata,
    output req_ready, resp_valid, resp_data, resp_err,
           address, write, read, writedata, byteenable
  );

  modport slave (
    output req_valid, req_op, req_addr, req_wdata, waitrequest, readdata,
    input  req_ready, resp_valid, resp_data, resp_err,
           address, write, read, writedata, byteenable
  );
endinterface

// File: rtl/mips_cpu_lsu.sv
// MIPS load/store unit: one request at a time from the core, one word-aligned
// Avalon-MM access per request, one-cycle response pulse with the extended or
// merged load result. Little-endian lanes.
// Optional macro MIPS_LSU_ALIGN_TRAP_EN: misaligned LH/LHU/SH/LW/SW return
// resp_err without touching the bus instead of being silently aligned.
module mips_cpu_lsu #(
  parameter int unsigned MAX_WAIT = 0  // stall cycles before abort; 0 = never
) (
  input  logic           clk,
  input  logic           reset,
  mips_cpu_lsu_if.master bus
);

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_LWL = 4'd5;
  localparam logic [3:0] OP_LWR = 4'd6;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

`ifdef MIPS_LSU_ALIGN_TRAP_EN
  localparam bit ALIGN_TRAP = 1'b1;
`else
  localparam bit ALIGN_TRAP = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t      state;
  logic [3:0]  op_q;
  logic [1:0]  b_q;
  logic [31:0] rt_q;
  logic [31:0] wait_cnt;

  logic [1:0]  b_in;
  logic        legal;
  logic        misal;
  logic        is_store;
  logic [3:0]  be_d;
  logic [31:0] wd_d;

  assign b_in = bus.req_addr[1:0];

  // Decode the incoming request: legality, direction, lane enables, store data
  always_comb begin
    legal    = 1'b0;
    misal    = 1'b0;
    is_store = 1'b0;
    be_d     = 4'b0000;
    wd_d     = 32'h0;
    case (bus.req_op)
      OP_LB, OP_LBU: begin
        legal = 1'b1;
        be_d  = 4'b0001 << b_in;
      end
      OP_LH, OP_LHU: begin
        legal = 1'b1;
        misal = ALIGN_TRAP && b_in[0];
        be_d  = b_in[1] ? 4'b1100 : 4'b0011;
      end
      OP_LW: begin
        legal = 1'b1;
        misal = ALIGN_TRAP && (b_in != 2'b00);
        be_d  = 4'b1111;
      end
      OP_LWL, OP_LWR: begin
        legal = 1'b1;
        be_d  = 4'b1111;
      end
      OP_SB: begin
        legal    = 1'b1;
        is_store = 1'b1;
        be_d     = 4'b0001 << b_in;
        wd_d     = {4{bus.req_wdata[7:0]}};
      end
      OP_SH: begin
        legal    = 1'b1;
        is_store = 1'b1;
        misal    = ALIGN_TRAP && b_in[0];
        be_d     = b_in[1] ? 4'b1100 : 4'b0011;
        wd_d     = {2{bus.req_wdata[15:0]}};
      end
      OP_SW: begin
        legal    = 1'b1;
        is_store = 1'b1;
        misal    = ALIGN_TRAP && (b_in != 2'b00);
        be_d     = 4'b1111;
        wd_d     = bus.req_wdata;
      end
      default: legal = 1'b0;
    endcase
  end

  logic [31:0] rd;
  logic [31:0] lane;
  logic [15:0] half;
  logic [31:0] ld_data;

  assign rd   = bus.readdata;
  assign lane = rd >> {b_q, 3'b000};
  assign half = b_q[1] ? rd[31:16] : rd[15:0];

  // Align, extend or merge the returned word for the latched load op
  always_comb begin
    ld_data = 32'h0;
    case (op_q)
      OP_LB:  ld_data = {{24{lane[7]}}, lane[7:0]};
      OP_LBU: ld_data = {24'h0, lane[7:0]};
      OP_LH:  ld_data = {{16{half[15]}}, half};
      OP_LHU: ld_data = {16'h0, half};
      OP_LW:  ld_data = rd;
      OP_LWL: begin
        case (b_q)
          2'd0:    ld_data = {rd[7:0],  rt_q[23:0]};
          2'd1:    ld_data = {rd[15:0], rt_q[15:0]};
          2'd2:    ld_data = {rd[23:0], rt_q[7:0]};
          default: ld_data = rd;
        endcase
      end
      OP_LWR: begin
        case (b_q)
          2'd0:    ld_data = rd;
          2'd1:    ld_data = {rt_q[31:24], rd[31:8]};
          2'd2:    ld_data = {rt_q[31:16], rd[31:16]};
          default: ld_data = {rt_q[31:8],  rd[31:24]};
        endcase
      end
      default: ld_data = 32'h0;  // stores return zero
    endcase
  end

  // Request FSM; every core and bus output is a register written here
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      op_q           <= 4'h0;
      b_q            <= 2'b00;
      rt_q           <= 32'h0;
      wait_cnt       <= 32'h0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= 32'h0;
      bus.resp_err   <= 1'b0;
      bus.read       <= 1'b0;
      bus.write      <= 1'b0;
      bus.address    <= 32'h0;
      bus.writedata  <= 32'h0;
      bus.byteenable <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_q          <= bus.req_op;
            b_q           <= b_in;
            rt_q          <= bus.req_wdata;
            wait_cnt      <= 32'h0;
            bus.req_ready <= 1'b0;
            if (!legal || misal) begin
              // illegal op or trapped misalignment: answer without a bus cycle
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_data  <= 32'h0;
            end else begin
              state          <= BUS;
              bus.address    <= {bus.req_addr[31:2], 2'b00};
              bus.byteenable <= be_d;
              bus.writedata  <= wd_d;
              bus.read       <= !is_store;
              bus.write      <= is_store;
            end
          end
        end
        BUS: begin
          if (!bus.waitrequest) begin
            state          <= RESP;
            bus.read       <= 1'b0;
            bus.write      <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_data  <= ld_data;
          end else if ((MAX_WAIT != 0) && (wait_cnt + 32'd1 == MAX_WAIT)) begin
            // slave stalled too long: abandon the access
            state          <= RESP;
            bus.read       <= 1'b0;
            bus.write      <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b1;
            bus.resp_data  <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        RESP: begin
          state          <= IDLE;
          bus.resp_valid <= 1'b0;
          bus.req_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_lsu.sv
// Directed bench for mips_cpu_lsu. The driver pushes expected responses and
// expected bus transfers into queues; a monitor pops and compares whenever the
// DUT presents resp_valid or completes a bus transfer. A memory model applies
// a per-request number of waitrequest cycles. Cycle index = rising edges seen.
module tb_mips_cpu_lsu;
  logic clk;
  logic reset;
  mips_cpu_lsu_if bus_if();

  mips_cpu_lsu #(.MAX_WAIT(4)) dut (.clk(clk), .reset(reset), .bus(bus_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] wd;
  } xfer_t;

  resp_t exp_q[$];
  xfer_t bus_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stall_n = 0;
  int stall_cnt = 0;
  logic [31:0] rd_val = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // memory model + bus monitor (single process so waitrequest and checks agree)
  logic        prev_strobe = 1'b0;
  logic [31:0] ref_addr, ref_wd;
  logic [3:0]  ref_be;
  logic        ref_rd;
  always @(negedge clk) begin
    bus_if.readdata = rd_val;
    if (bus_if.read || bus_if.write) begin
      if (!prev_strobe) begin
        ref_addr = bus_if.address; ref_wd = bus_if.writedata;
        ref_be = bus_if.byteenable; ref_rd = bus_if.read;
      end else begin
        chk("hold_addr", bus_if.address, ref_addr);
        chk("hold_be", {28'h0, bus_if.byteenable}, {28'h0, ref_be});
        chk("hold_wd", bus_if.writedata, ref_wd);
        chk("hold_read", {31'h0, bus_if.read}, {31'h0, ref_rd});
      end
      if (stall_cnt < stall_n) begin
        bus_if.waitrequest = 1'b1;
        stall_cnt++;
      end else begin
        bus_if.waitrequest = 1'b0;
        if (bus_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_bus: got addr %h rd %b wr %b want no transfer",
                   bus_if.address, bus_if.read, bus_if.write);
        end else begin
          xfer_t x;
          x = bus_q.pop_front();
          chk("bus_addr", bus_if.address, x.addr);
          chk("bus_write", {31'h0, bus_if.write}, {31'h0, x.wr});
          chk("bus_read", {31'h0, bus_if.read}, {31'h0, !x.wr});
          chk("bus_be", {28'h0, bus_if.byteenable}, {28'h0, x.be});
          if (x.wr) chk("bus_wdata", bus_if.writedata, x.wd);
        end
      end
      prev_strobe = 1'b1;
    end else begin
      bus_if.waitrequest = 1'b0;
      stall_cnt = 0;
      prev_strobe = 1'b0;
    end
  end

  // response monitor
  always @(negedge clk) begin
    if (!reset && bus_if.resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_resp: got data %h err %b want none",
                 bus_if.resp_data, bus_if.resp_err);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        chk("resp_data", bus_if.resp_data, e.data);
        chk("resp_err", {31'h0, bus_if.resp_err}, {31'h0, e.err});
        chk("resp_cycle", cyc, e.cyc);
      end
    end
  end

  // lat: cycles from the accepting edge to the edge that raises resp_valid
  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt,
                       input logic [31:0] rd, input int stalls, input logic [31:0] edata,
                       input logic eerr, input int lat, input bit pbus,
                       input logic [31:0] eaddr, input logic [3:0] ebe, input logic ewr,
                       input logic [31:0] ewd);
    int guard;
    resp_t e;
    xfer_t x;
    guard = 0;
    @(negedge clk);
    bus_if.req_valid = 1'b1;
    bus_if.req_op = op;
    bus_if.req_addr = addr;
    bus_if.req_wdata = rt;
    while (bus_if.req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (bus_if.req_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL accept_timeout: got req_ready %b want 1", bus_if.req_ready);
      bus_if.req_valid = 1'b0;
      return;
    end
    stall_n = stalls;
    rd_val = rd;
    e.data = edata; e.err = eerr; e.cyc = cyc + 1 + lat;
    exp_q.push_back(e);
    if (pbus) begin
      x.addr = eaddr; x.wr = ewr; x.be = ebe; x.wd = ewd;
      bus_q.push_back(x);
    end
    @(negedge clk);
    bus_if.req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    total++;
    if (exp_q.size() != 0 || bus_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d resp / %0d bus pending want 0", exp_q.size(), bus_q.size());
      exp_q.delete();
      bus_q.delete();
    end
  endtask

  initial begin
    bus_if.req_valid = 1'b0;
    bus_if.req_op = 4'h0;
    bus_if.req_addr = 32'h0;
    bus_if.req_wdata = 32'h0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'h0, bus_if.req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, bus_if.resp_valid}, 32'h0);
    chk("rst_resp_data", bus_if.resp_data, 32'h0);
    chk("rst_resp_err", {31'h0, bus_if.resp_err}, 32'h0);
    chk("rst_strobes", {30'h0, bus_if.read, bus_if.write}, 32'h0);
    chk("rst_address", bus_if.address, 32'h0);
    chk("rst_wdata", bus_if.writedata, 32'h0);
    chk("rst_be", {28'h0, bus_if.byteenable}, 32'h0);
    reset = 1'b0;

    //    op     addr          rt            rd            st  data          err lat bus addr         be       wr wd
    issue(4'd0,  32'h103,      32'h0,        32'h80FF1234, 0,  32'hFFFFFF80, 0,  1,  1,  32'h100,     4'b1000, 0, 0);
    issue(4'd9,  32'h202,      32'hAAAA5678, 32'h0,        0,  32'h0,        0,  1,  1,  32'h200,     4'b1100, 1, 32'h56785678);
    issue(4'd4,  32'h40,       32'h0,        32'hDEADBEEF, 3,  32'hDEADBEEF, 0,  4,  1,  32'h40,      4'b1111, 0, 0);
    issue(4'd5,  32'h1,        32'hAABBCCDD, 32'h44332211, 0,  32'h2211CCDD, 0,  1,  1,  32'h0,       4'b1111, 0, 0);
    issue(4'd6,  32'h1,        32'hAABBCCDD, 32'h44332211, 0,  32'hAA443322, 0,  1,  1,  32'h0,       4'b1111, 0, 0);
    issue(4'd5,  32'h3,        32'hAABBCCDD, 32'h44332211, 1,  32'h44332211, 0,  2,  1,  32'h0,       4'b1111, 0, 0);
    issue(4'd6,  32'h0,        32'hAABBCCDD, 32'h44332211, 0,  32'h44332211, 0,  1,  1,  32'h0,       4'b1111, 0, 0);
    issue(4'd1,  32'h101,      32'h0,        32'h80FF1234, 0,  32'h00000012, 0,  1,  1,  32'h100,     4'b0010, 0, 0);
    issue(4'd2,  32'h102,      32'h0,        32'h80FF1234, 2,  32'hFFFF80FF, 0,  3,  1,  32'h100,     4'b1100, 0, 0);
    issue(4'd3,  32'h100,      32'h0,        32'h8234F234, 0,  32'h0000F234, 0,  1,  1,  32'h100,     4'b0011, 0, 0);
    issue(4'd8,  32'h305,      32'h123456A5, 32'h0,        0,  32'h0,        0,  1,  1,  32'h304,     4'b0010, 1, 32'hA5A5A5A5);
    issue(4'd10, 32'hFFFF_0400,32'hCAFEF00D, 32'h0,        1,  32'h0,        0,  2,  1,  32'hFFFF0400,4'b1111, 1, 32'hCAFEF00D);
    issue(4'd7,  32'h100,      32'h0,        32'h0,        0,  32'h0,        1,  0,  0,  32'h0,       4'b0000, 0, 0);
    issue(4'd15, 32'h100,      32'h0,        32'h0,        0,  32'h0,        1,  0,  0,  32'h0,       4'b0000, 0, 0);
`ifdef MIPS_LSU_ALIGN_TRAP_EN
    issue(4'd4,  32'h6,        32'h0,        32'h11223344, 0,  32'h0,        1,  0,  0,  32'h0,       4'b0000, 0, 0);
    issue(4'd9,  32'h203,      32'h1234,     32'h0,        0,  32'h0,        1,  0,  0,  32'h0,       4'b0000, 0, 0);
`else
    issue(4'd4,  32'h6,        32'h0,        32'h11223344, 0,  32'h11223344, 0,  1,  1,  32'h4,       4'b1111, 0, 0);
    issue(4'd9,  32'h203,      32'h1234,     32'h0,        0,  32'h0,        0,  1,  1,  32'h200,     4'b1100, 1, 32'h12341234);
`endif
    // waitrequest stuck high: abandoned after 4 stalled cycles
    issue(4'd4,  32'h500,      32'h0,        32'h12345678, 1000, 32'h0,      1,  4,  0,  32'h0,       4'b0000, 0, 0);
    drain();

    // reset while the bus is stalled: strobes drop, no response, ready again
    @(negedge clk);
    stall_n = 1000;
    bus_if.req_valid = 1'b1;
    bus_if.req_op = 4'd4;
    bus_if.req_addr = 32'h10;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    chk("mid_read_up", {31'h0, bus_if.read}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_read", {31'h0, bus_if.read}, 32'h0);
    chk("mid_rst_resp_valid", {31'h0, bus_if.resp_valid}, 32'h0);
    chk("mid_rst_req_ready", {31'h0, bus_if.req_ready}, 32'h1);
    repeat (6) @(negedge clk);

    // unit still usable afterwards
    issue(4'd0,  32'h22,       32'h0,        32'h00410000, 0,  32'h00000041, 0,  1,  1,  32'h20,      4'b0100, 0, 0);
    drain();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mips_cpu_lsu.md
Name: mips_cpu_lsu

Overview:
Load/store unit between the MIPS core control FSM and the Avalon-MM master port. It accepts one memory request at a time from the core: loads LB/LBU/LH/LHU/LW/LWL/LWR and stores SB/SH/SW. For each request it issues a single word-aligned Avalon read or write with the correct byteenable and lane-replicated writedata. It obeys waitrequest, then returns the aligned, extended or merged load result to the core as a one-cycle response pulse. Byte order is little-endian: byte offset b maps to readdata/writedata bits [8b+7:8b] and byteenable[b].

Parameters:
MAX_WAIT, 0, waitrequest timeout in cycles; 0 disables the timeout. Otherwise, once MAX_WAIT consecutive stalled bus cycles have elapsed, the transaction is abandoned with err=1.

Ports:
clk  input  1  clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  core presents a request
req_ready  output  1  high only in IDLE
req_op  input  4  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 8 SB, 9 SH, 10 SW; all other codes are illegal
req_addr  input  32  byte address
req_wdata  input  32  rt value: store data, and merge source for LWL/LWR
resp_valid  output  1  one-cycle completion pulse
resp_data  output  32  load result; 0 for stores and errors
resp_err  output  1  qualified by resp_valid
address  output  32  {addr[31:2],2'b00}
write  output  1  Avalon write strobe
read  output  1  Avalon read strobe
waitrequest  input  1  slave stall
writedata  output  32  lane-replicated store data
byteenable  output  4  active lanes
readdata  input  32  valid when read && !waitrequest

Behaviour:
- Clock is clk; reset is synchronous, active-high (reset). All outputs are registered.
- Reset values: req_ready=1, resp_valid=0, resp_data=0, resp_err=0, read=0, write=0, address=0, writedata=0, byteenable=0, state=IDLE, wait counter=0.
- States: IDLE, BUS, RESP.
- IDLE: on req_valid, latch op, addr, wdata and b=addr[1:0]; clear req_ready.
  - Illegal op: go to RESP with err=1; no bus cycle.
  - Legal op: go to BUS, driving read or write, address, byteenable and writedata from the next cycle.
- BUS: hold all bus outputs stable while waitrequest=1; increment the wait counter.
  - On waitrequest=0: drop read/write at the next edge, capture readdata for loads, go to RESP.
  - If MAX_WAIT!=0 and the counter reaches MAX_WAIT: drop strobes, err=1, go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE with req_ready=1.
- Latency: request accepted at edge N, strobe visible N..N+1, zero-wait completion, resp_valid in cycle N+2. Each stall cycle adds one. Back-to-back throughput is one request per 3 cycles.
- Loads:
  - Byteenable: LB/LBU=1<<b; LH/LHU=b[1]?1100:0011; LW/LWL/LWR=1111.
  - LB/LH sign-extend; LBU/LHU zero-extend the selected lane.
  - LWL: (rd<<(8*(3-b))) | (rt & ((1<<(8*(3-b)))-1)).
  - LWR: (rd>>(8*b)) | (rt & ~(32'hFFFFFFFF>>(8*b))).
- Stores:
  - SB: writedata={4{rt[7:0]}}, be=1<<b.
  - SH: writedata={2{rt[15:0]}}, be=b[1]?1100:0011.
  - SW: writedata=rt, be=1111.
- Misalignment without the macro: low bits are ignored. LH/LHU/SH use b[1] only; LW/SW use offset 0; err=0.
- req_valid in BUS/RESP is ignored (req_ready=0). The core holds the request until accepted.
- Reset mid-transaction: strobes and resp_valid are cleared at that edge; the transaction is abandoned without a response.

Optional Feature:
MIPS_LSU_ALIGN_TRAP_EN
- Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, go IDLE->RESP with resp_err=1, resp_data=0 and no bus cycle (address error for the core's exception logic). LWL/LWR are unaffected.
- Undefined: misaligned addresses are silently aligned as described in Behaviour.

Test Plan:
- LB addr 0x103, readdata 0x80FF1234, no wait -> address 0x100, read=1, be=1000, resp_data=0xFFFFFF80, resp_valid at N+2.
- SH addr 0x202, rt=0xAAAA5678 -> write=1, address 0x200, be=1100, writedata=0x56785678, resp_data=0, err=0.
- LW with waitrequest high 3 cycles -> read/address/be held stable for 4 cycles, resp_valid at N+5, data=readdata.
- LWL addr 0x1 with rd=0x44332211, rt=0xAABBCCDD -> 0x2211CCDD. LWR same inputs -> 0xAA443322.
- LW addr 0x6: with MIPS_LSU_ALIGN_TRAP_EN -> no read, resp_err=1 at N+1; without -> read 0x4, err=0.
- MAX_WAIT=4 with waitrequest stuck high -> strobes drop, resp_err=1. Reset asserted in BUS -> read=0 next edge, no resp_valid, req_ready=1.
